preprocess_unit: RTL and testbench



---
 rtl/preprocess_unit_pkg.sv | 32 +++
 rtl/preprocess_line_buf.sv | 43 ++++
 rtl/preprocess_unit.sv | 158 +++++++++++++++
 tb/tb_preprocess_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preprocess_unit_pkg.sv
// Shared types and sizing for the image-filter front end (preprocess_unit).
// Optional macro ZERO_PAD_EN selects the zero-padded scan (one window per column).
`timescale 1ns/1ps
package preprocess_unit_pkg;

   localparam int MAX_BUF_ROWS = 3;
   localparam int MAX_IMG_COLS = 540;
   localparam int ROW_W        = 2;
   localparam int COL_W        = 10;

   typedef logic [7:0]       pixel_t;
   typedef logic [ROW_W-1:0] row_t;
   typedef logic [COL_W-1:0] col_t;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      READY = 2'd1,
      SCAN  = 2'd2
   } state_t;

`ifdef ZERO_PAD_EN
   localparam int NUM_WIN = MAX_IMG_COLS;
`else
   localparam int NUM_WIN = MAX_IMG_COLS - 2;
`endif

   localparam row_t LAST_ROW = row_t'(MAX_BUF_ROWS - 1);
   localparam col_t LAST_COL = col_t'(MAX_IMG_COLS - 1);
   localparam col_t LAST_WIN = col_t'(NUM_WIN - 1);
   localparam col_t COL_LIM  = col_t'(MAX_IMG_COLS);

endpackage

// File: rtl/preprocess_line_buf.sv
// One buffered image row: MAX_IMG_COLS bytes, one write port and three
// combinational read taps at rd_col, rd_col+1, rd_col+2. Tap addresses wrap
// in COL_W bits and any address outside the row reads as 8'h00, which lets the
// parent express left/right zero padding by offsetting rd_col.
`timescale 1ns/1ps
module preprocess_line_buf
   import preprocess_unit_pkg::*;
(
   input  logic   clk,
   input  logic   we,
   input  col_t   wr_col,
   input  pixel_t wr_data,
   input  col_t   rd_col,
   output pixel_t tap_0,
   output pixel_t tap_1,
   output pixel_t tap_2
);

   pixel_t mem [MAX_IMG_COLS];
   col_t   idx_1;
   col_t   idx_2;

   assign idx_1 = rd_col + col_t'(1);
   assign idx_2 = rd_col + col_t'(2);

   // Row storage: contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_col] <= wr_data;
      end
   end

   // Read taps with out-of-row addresses forced to zero.
   always_comb begin
      tap_0 = '0;
      tap_1 = '0;
      tap_2 = '0;
      if (rd_col < COL_LIM) tap_0 = mem[rd_col];
      if (idx_1  < COL_LIM) tap_1 = mem[idx_1];
      if (idx_2  < COL_LIM) tap_2 = mem[idx_2];
   end

endmodule

// File: rtl/preprocess_unit.sv
// Image-filter front end: buffers three rows streamed byte-wise, then emits
// one registered 3x3 window per enabled cycle to the convolution core.
// Optional macro ZERO_PAD_EN: windows centred on every column with zero
// padding at both row ends (MAX_IMG_COLS windows instead of MAX_IMG_COLS-2).
`timescale 1ns/1ps
module preprocess_unit
   import preprocess_unit_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   core_en_i,
   input  logic   fetch_en_i,
   input  pixel_t data_i,
   output logic   fetch_done_o,
   output logic   core_done_o,
   output pixel_t data_0_0_o,
   output pixel_t data_0_1_o,
   output pixel_t data_0_2_o,
   output pixel_t data_1_0_o,
   output pixel_t data_1_1_o,
   output pixel_t data_1_2_o,
   output pixel_t data_2_0_o,
   output pixel_t data_2_1_o,
   output pixel_t data_2_2_o,
   output logic   core_en_o,
   output logic   n_segment_up_o,
   output row_t   cnt_buf_row,
   output col_t   cnt_buf_col,
   output col_t   cnt_pos_col
);

   state_t state;
   state_t state_nxt;
   logic   fill_wr;
   logic   fill_last;
   logic   sample;
   logic   scan_last;
   col_t   rd_col;
   pixel_t tap    [MAX_BUF_ROWS][3];
   pixel_t win_p1 [MAX_BUF_ROWS][3];

`ifdef ZERO_PAD_EN
   // Window centred on cnt_pos_col: left tap sits one column to the left.
   assign rd_col = cnt_pos_col - col_t'(1);
`else
   assign rd_col = cnt_pos_col;
`endif

   for (genvar r = 0; r < MAX_BUF_ROWS; r++) begin : g_row
      preprocess_line_buf u_line_buf (
         .clk     (clk),
         .we      (fill_wr && (cnt_buf_row == row_t'(r))),
         .wr_col  (cnt_buf_col),
         .wr_data (data_i),
         .rd_col  (rd_col),
         .tap_0   (tap[r][0]),
         .tap_1   (tap[r][1]),
         .tap_2   (tap[r][2])
      );
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_nxt;
   end

   // Next state and per-cycle strobes; READY samples the first window itself.
   always_comb begin
      state_nxt = state;
      fill_wr   = 1'b0;
      fill_last = 1'b0;
      sample    = 1'b0;
      scan_last = 1'b0;
      case (state)
         FILL: begin
            if (fetch_en_i) begin
               fill_wr = 1'b1;
               if (cnt_buf_row == LAST_ROW && cnt_buf_col == LAST_COL) begin
                  fill_last = 1'b1;
                  state_nxt = READY;
               end
            end
         end
         READY, SCAN: begin
            if (core_en_i) begin
               sample    = 1'b1;
               state_nxt = SCAN;
               if (cnt_pos_col == LAST_WIN) begin
                  scan_last = 1'b1;
                  state_nxt = FILL;
               end
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   // Fill position and scan column counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_buf_row <= '0;
         cnt_buf_col <= '0;
         cnt_pos_col <= '0;
      end else begin
         if (fill_wr) begin
            if (cnt_buf_col == LAST_COL) begin
               cnt_buf_col <= '0;
               cnt_buf_row <= fill_last ? row_t'(0) : cnt_buf_row + row_t'(1);
            end else begin
               cnt_buf_col <= cnt_buf_col + col_t'(1);
            end
         end
         if (sample) begin
            cnt_pos_col <= scan_last ? col_t'(0) : cnt_pos_col + col_t'(1);
         end
      end
   end

   // ---- stage p1: registered window and its status pulses ----
   // Status pulses are one cycle; window data holds between samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_done_o   <= 1'b0;
         core_en_o      <= 1'b0;
         core_done_o    <= 1'b0;
         n_segment_up_o <= 1'b0;
         for (int r = 0; r < MAX_BUF_ROWS; r++) begin
            for (int k = 0; k < 3; k++) begin
               win_p1[r][k] <= '0;
            end
         end
      end else begin
         fetch_done_o   <= fill_last;
         core_en_o      <= sample;
         core_done_o    <= scan_last;
         n_segment_up_o <= scan_last;
         if (sample) begin
            for (int r = 0; r < MAX_BUF_ROWS; r++) begin
               for (int k = 0; k < 3; k++) begin
                  win_p1[r][k] <= tap[r][k];
               end
            end
         end
      end
   end

   assign data_0_0_o = win_p1[0][0];
   assign data_0_1_o = win_p1[0][1];
   assign data_0_2_o = win_p1[0][2];
   assign data_1_0_o = win_p1[1][0];
   assign data_1_1_o = win_p1[1][1];
   assign data_1_2_o = win_p1[1][2];
   assign data_2_0_o = win_p1[2][0];
   assign data_2_1_o = win_p1[2][1];
   assign data_2_2_o = win_p1[2][2];

endmodule

// File: tb/tb_preprocess_unit.sv
// Bench for preprocess_unit: reference image model, table of known window
// pixels, and multi-segment fill/scan sequences with stalls and resets.
`timescale 1ns/1ps
module tb_preprocess_unit;
   import preprocess_unit_pkg::*;

   localparam int ROWS  = 3;
   localparam int COLS  = 540;
   localparam int TOTAL = ROWS * COLS;
`ifdef ZERO_PAD_EN
   localparam int NWIN = COLS;
`else
   localparam int NWIN = COLS - 2;
`endif

   logic       clk;
   logic       rst_n;
   logic       core_en_i;
   logic       fetch_en_i;
   logic [7:0] data_i;
   logic       fetch_done_o, core_done_o, core_en_o, n_segment_up_o;
   logic [7:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
   logic [1:0] cnt_buf_row;
   logic [9:0] cnt_buf_col, cnt_pos_col;
   logic [7:0] dout [3][3];

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] img  [ROWS][COLS];
   logic [7:0] last [3][3];
   logic [7:0] cap  [COLS][3][3];

   typedef struct {
      int         win;
      int         r;
      int         k;
      logic [7:0] exp;
   } tv_t;
   tv_t tbl [8];

   preprocess_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .core_en_i      (core_en_i),
      .fetch_en_i     (fetch_en_i),
      .data_i         (data_i),
      .fetch_done_o   (fetch_done_o),
      .core_done_o    (core_done_o),
      .data_0_0_o     (d00),
      .data_0_1_o     (d01),
      .data_0_2_o     (d02),
      .data_1_0_o     (d10),
      .data_1_1_o     (d11),
      .data_1_2_o     (d12),
      .data_2_0_o     (d20),
      .data_2_1_o     (d21),
      .data_2_2_o     (d22),
      .core_en_o      (core_en_o),
      .n_segment_up_o (n_segment_up_o),
      .cnt_buf_row    (cnt_buf_row),
      .cnt_buf_col    (cnt_buf_col),
      .cnt_pos_col    (cnt_pos_col)
   );

   assign dout[0][0] = d00;
   assign dout[0][1] = d01;
   assign dout[0][2] = d02;
   assign dout[1][0] = d10;
   assign dout[1][1] = d11;
   assign dout[1][2] = d12;
   assign dout[2][0] = d20;
   assign dout[2][1] = d21;
   assign dout[2][2] = d22;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected window pixel straight from the image model.
   function automatic logic [7:0] ref_px(input int r, input int w, input int k);
      int c;
`ifdef ZERO_PAD_EN
      c = w + k - 1;
`else
      c = w + k;
`endif
      if (c < 0 || c >= COLS) return 8'h00;
      return img[r][c];
   endfunction

   task automatic chk_reset(input string tag);
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 3; k++)
            chk($sformatf("%s data_%0d_%0d", tag, r, k), dout[r][k], 0);
      chk({tag, " fetch_done_o"}, fetch_done_o, 0);
      chk({tag, " core_done_o"}, core_done_o, 0);
      chk({tag, " core_en_o"}, core_en_o, 0);
      chk({tag, " n_segment_up_o"}, n_segment_up_o, 0);
      chk({tag, " cnt_buf_row"}, cnt_buf_row, 0);
      chk({tag, " cnt_buf_col"}, cnt_buf_col, 0);
      chk({tag, " cnt_pos_col"}, cnt_pos_col, 0);
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 3; k++)
            last[r][k] = 8'h00;
   endtask

   task automatic chk_held(input string tag);
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 3; k++)
            chk($sformatf("%s hold data_%0d_%0d", tag, r, k), dout[r][k], last[r][k]);
   endtask

   // mode: 0 continuous, 1 every other cycle, 2 random 30% gaps.
   task automatic do_fill(input int mode, input bit rnd_data, input string tag);
      int n;
      int cyc;
      bit fe;
      n = 0;
      cyc = 0;
      while (n < TOTAL && cyc < 20000) begin
         case (mode)
            0:       fe = 1'b1;
            1:       fe = (cyc % 2 == 0);
            default: fe = ($urandom_range(99) >= 30);
         endcase
         fetch_en_i = fe;
         data_i     = rnd_data ? 8'($urandom) : 8'(n);
         core_en_i  = 1'($urandom_range(1));
         step();
         cyc++;
         if (fe) begin
            img[n / COLS][n % COLS] = data_i;
            n++;
         end
         chk({tag, " fill core_en_o"}, core_en_o, 0);
         chk({tag, " fill core_done_o"}, core_done_o, 0);
         chk({tag, " fill n_segment_up_o"}, n_segment_up_o, 0);
         chk({tag, " fill fetch_done_o"}, fetch_done_o, (fe && n == TOTAL));
         chk({tag, " fill cnt_buf_row"}, cnt_buf_row, (n % TOTAL) / COLS);
         chk({tag, " fill cnt_buf_col"}, cnt_buf_col, (n % TOTAL) % COLS);
      end
      chk({tag, " fill completed within budget"}, (n == TOTAL), 1);
      fetch_en_i = 1'b0;
      core_en_i  = 1'b0;
   endtask

   task automatic do_ready(input int cycles, input bit inject, input string tag);
      for (int i = 0; i < cycles; i++) begin
         core_en_i  = 1'b0;
         fetch_en_i = inject;
         data_i     = 8'hFF;
         step();
         chk({tag, " ready core_en_o"}, core_en_o, 0);
         chk({tag, " ready fetch_done_o"}, fetch_done_o, 0);
         chk({tag, " ready cnt_pos_col"}, cnt_pos_col, 0);
         chk_held({tag, " ready"});
      end
   endtask

   // Returns early (after a reset sequence) when abort_at windows are out.
   task automatic do_scan(input int gap, input int pause_at, input bit inject,
                          input int abort_at, input string tag);
      int issued;
      int cyc;
      int paused;
      bit ce;
      issued = 0;
      cyc = 0;
      paused = 0;
      while (issued < NWIN && cyc < 20000) begin
         if (issued == abort_at) begin
            rst_n      = 1'b0;
            core_en_i  = 1'b1;
            fetch_en_i = 1'b1;
            #1;
            chk_reset({tag, " async reset"});
            step();
            step();
            chk_reset({tag, " mid-scan reset"});
            rst_n = 1'b1;
            for (int i = 0; i < 10; i++) begin
               core_en_i  = 1'b1;
               fetch_en_i = 1'b0;
               step();
               chk({tag, " post-reset core_en_o"}, core_en_o, 0);
               chk({tag, " post-reset cnt_pos_col"}, cnt_pos_col, 0);
            end
            core_en_i = 1'b0;
            return;
         end
         ce = ($urandom_range(99) >= gap);
         if (issued == pause_at && paused < 5) begin
            ce = 1'b0;
            paused++;
         end
         core_en_i  = ce;
         fetch_en_i = inject ? 1'($urandom_range(1)) : 1'b0;
         data_i     = 8'hFF;
         step();
         cyc++;
         chk({tag, " scan fetch_done_o"}, fetch_done_o, 0);
         if (ce) begin
            chk($sformatf("%s core_en_o w%0d", tag, issued), core_en_o, 1);
            chk($sformatf("%s core_done_o w%0d", tag, issued), core_done_o, (issued == NWIN - 1));
            chk($sformatf("%s n_segment_up_o w%0d", tag, issued), n_segment_up_o, (issued == NWIN - 1));
            for (int r = 0; r < 3; r++) begin
               for (int k = 0; k < 3; k++) begin
                  chk($sformatf("%s w%0d data_%0d_%0d", tag, issued, r, k), dout[r][k], ref_px(r, issued, k));
                  last[r][k] = ref_px(r, issued, k);
                  cap[issued][r][k] = dout[r][k];
               end
            end
            issued++;
         end else begin
            chk({tag, " pause core_en_o"}, core_en_o, 0);
            chk({tag, " pause core_done_o"}, core_done_o, 0);
            chk_held({tag, " pause"});
         end
         chk($sformatf("%s cnt_pos_col after %0d", tag, issued), cnt_pos_col, issued % NWIN);
      end
      chk({tag, " scan completed within budget"}, (issued == NWIN), 1);
      core_en_i  = 1'b0;
      fetch_en_i = 1'b0;
   endtask

   initial begin
`ifdef ZERO_PAD_EN
      tbl[0] = '{0,   0, 0, 8'd0};
      tbl[1] = '{0,   0, 1, 8'd0};
      tbl[2] = '{0,   0, 2, 8'd1};
      tbl[3] = '{1,   1, 0, 8'd28};
      tbl[4] = '{539, 2, 2, 8'd0};
      tbl[5] = '{539, 2, 1, 8'd83};
      tbl[6] = '{101, 1, 2, 8'd130};
      tbl[7] = '{256, 0, 1, 8'd0};
`else
      tbl[0] = '{0,   0, 0, 8'd0};
      tbl[1] = '{0,   0, 1, 8'd1};
      tbl[2] = '{0,   0, 2, 8'd2};
      tbl[3] = '{0,   1, 0, 8'd28};
      tbl[4] = '{0,   2, 2, 8'd58};
      tbl[5] = '{100, 1, 1, 8'd129};
      tbl[6] = '{537, 2, 2, 8'd83};
      tbl[7] = '{300, 2, 0, 8'd100};
`endif
      rst_n      = 1'b0;
      core_en_i  = 1'b0;
      fetch_en_i = 1'b0;
      data_i     = 8'h00;
      step();
      step();
      step();
      chk_reset("reset");
      rst_n = 1'b1;

      // Segment 1: index data, no stalls; then known-pixel table.
      do_fill(0, 1'b0, "seg1");
      do_scan(0, -1, 1'b0, -1, "seg1");
      for (int i = 0; i < $size(tbl); i++)
         chk($sformatf("table w%0d data_%0d_%0d", tbl[i].win, tbl[i].r, tbl[i].k),
             cap[tbl[i].win][tbl[i].r][tbl[i].k], tbl[i].exp);

      // Segment 2: alternating fetch gaps, 5-cycle pause, ignored bytes.
      do_fill(1, 1'b0, "seg2");
      do_ready(4, 1'b1, "seg2");
      do_scan(0, 200, 1'b1, -1, "seg2");

      // Segment 3: random data and stalls, reset after window 100.
      do_fill(2, 1'b1, "seg3");
      do_ready(2, 1'b1, "seg3");
      do_scan(30, -1, 1'b1, 101, "seg3");

      // Segment 4: a fresh fill is needed after the reset.
      do_fill(2, 1'b1, "seg4");
      do_scan(30, -1, 1'b1, -1, "seg4");
      do_fill(0, 1'b1, "seg5");
      do_scan(0, -1, 1'b0, -1, "seg5");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
